// File: rtl/pong_sched_pkg.sv
// Shared types and constants for the frame tick scheduler.
package pong_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } sched_state_e;

  localparam int FRAME_CNT_W = 16;

  // Stage index needs at least one bit even for a single stage.
  function automatic int idx_width(input int n_stages);
    return (n_stages > 1) ? $clog2(n_stages) : 1;
  endfunction

endpackage

// File: rtl/sched_timeout.sv
// Per-stage wait counter: zeroed by clear_i, counts enabled cycles,
// expired_o flags the last permitted wait cycle.
module sched_timeout #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/game_tick_sched.sv
// Frame tick scheduler: on each accepted strobe, starts the update stages
// one after another, waiting for each stage's done (or timeout).
//
//   state | meaning
//   IDLE  | no frame in progress, waiting for an unpaused strobe
//   ISSUE | one-cycle start pulse on stage_start_o[idx]
//   WAIT  | waiting for stage_done_i[idx] or wait-counter expiry
module game_tick_sched
  import pong_sched_pkg::*;
#(
  parameter int N_STAGES       = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   strobe_i,
  input  logic                   pause_i,
  input  logic                   clear_i,
  input  logic [N_STAGES-1:0]    stage_done_i,
  output logic [N_STAGES-1:0]    stage_start_o,
  output logic                   busy_o,
  output logic                   overrun_o,
  output logic                   timeout_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

  localparam int IDX_W = idx_width(N_STAGES);

  sched_state_e            state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [N_STAGES-1:0]     stage_start_q, stage_start_d;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;
  logic                    timeout_q, timeout_d;
  logic [FRAME_CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

  logic done_cur;
  logic expired;
  logic tmr_clear;
  logic tmr_enable;
  logic overrun_set;
  logic timeout_set;
  logic stage_fin;

  assign done_cur   = stage_done_i[idx_q];
  assign tmr_clear  = (state_q != WAIT);
  assign tmr_enable = (state_q == WAIT) && !done_cur;

  sched_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (tmr_clear),
    .enable_i (tmr_enable),
    .expired_o(expired)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;

    overrun_set = strobe_i && (state_q != IDLE);
    timeout_set = (state_q == WAIT) && !done_cur && expired;
    stage_fin   = (state_q == WAIT) && (done_cur || expired);

    case (state_q)
      IDLE: begin
        if (strobe_i && !pause_i) begin
          idx_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (stage_fin) begin
          if (idx_q == IDX_W'(N_STAGES - 1)) begin
            state_d     = IDLE;
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ISSUE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    stage_start_d = '0;
    if (state_d == ISSUE) begin
      stage_start_d = N_STAGES'(1) << idx_d;
    end
    busy_d = (state_d != IDLE);

    // A set event in the same cycle beats clear_i.
    overrun_d = overrun_q;
    if (overrun_set) begin
      overrun_d = 1'b1;
    end else if (clear_i) begin
      overrun_d = 1'b0;
    end

    timeout_d = timeout_q;
    if (timeout_set) begin
      timeout_d = 1'b1;
    end else if (clear_i) begin
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      stage_start_q <= '0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      stage_start_q <= stage_start_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign stage_start_o = stage_start_q;
  assign busy_o        = busy_q;
  assign overrun_o     = overrun_q;
  assign timeout_o     = timeout_q;
  assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_game_tick_sched.sv
// Self-checking bench for game_tick_sched: frame vectors from a table plus
// hand sequences for counter wrap and mid-frame reset.
module tb_game_tick_sched;

  localparam int N   = 4;
  localparam int TMO = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          strobe_i;
  logic          pause_i;
  logic          clear_i;
  logic [N-1:0]  stage_done_i;
  logic [N-1:0]  stage_start_o;
  logic          busy_o;
  logic          overrun_o;
  logic          timeout_o;
  logic [15:0]   frame_cnt_o;

  game_tick_sched #(
    .N_STAGES      (N),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .strobe_i     (strobe_i),
    .pause_i      (pause_i),
    .clear_i      (clear_i),
    .stage_done_i (stage_done_i),
    .stage_start_o(stage_start_o),
    .busy_o       (busy_o),
    .overrun_o    (overrun_o),
    .timeout_o    (timeout_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int chk = 0;
  int err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk++;
    if (act !== req) begin
      err++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard of expected start pulses: absolute cycle and one-hot value.
  typedef struct {
    int           cyc;
    logic [N-1:0] val;
  } ev_t;
  ev_t sb[$];
  bit  mon_en = 1'b0;

  always @(negedge clk_i) begin
    if (mon_en && stage_start_o != '0) begin
      if (sb.size() == 0) begin
        chk++;
        err++;
        $display("FAIL unexpected_start: actual %b required none (cycle %0d)", stage_start_o, cyc);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("start_cycle", cyc, e.cyc);
        check("start_value", {28'b0, stage_start_o}, {28'b0, e.val});
      end
    end
  end

  // Offsets below are relative to the cycle in which the strobe is driven.
  typedef struct {
    int              pause_at;
    logic [3:0][7:0] dly;
    int              ovr_at;
    int              clr_at;
    int              stray_at;
    logic [N-1:0]    stray_mask;
    logic [3:0][7:0] exp_start;
    int              exp_end;
    bit              exp_ovr;
    bit              exp_tmo;
    bit              exp_inc;
  } vec_t;

  function automatic vec_t mk(int pause_at, int d0, int d1, int d2, int d3,
                              int ovr_at, int clr_at, int stray_at, logic [N-1:0] mask,
                              int s0, int s1, int s2, int s3, int e_end,
                              bit ovr, bit tmo, bit inc);
    vec_t v;
    v.pause_at     = pause_at;
    v.dly[0]       = 8'(d0);
    v.dly[1]       = 8'(d1);
    v.dly[2]       = 8'(d2);
    v.dly[3]       = 8'(d3);
    v.ovr_at       = ovr_at;
    v.clr_at       = clr_at;
    v.stray_at     = stray_at;
    v.stray_mask   = mask;
    v.exp_start[0] = 8'(s0);
    v.exp_start[1] = 8'(s1);
    v.exp_start[2] = 8'(s2);
    v.exp_start[3] = 8'(s3);
    v.exp_end      = e_end;
    v.exp_ovr      = ovr;
    v.exp_tmo      = tmo;
    v.exp_inc      = inc;
    return v;
  endfunction

  logic [15:0] exp_frames = 16'd0;

  task automatic run_vec(input int id, input vec_t v);
    int  s;
    bit  active;
    logic [N-1:0] d;
    active = (v.pause_at != 0);
    @(negedge clk_i);
    s = cyc;
    if (active) begin
      for (int k = 0; k < N; k++) begin
        ev_t e;
        e.cyc = s + int'(v.exp_start[k]);
        e.val = N'(1) << k;
        sb.push_back(e);
      end
    end
    for (int c = 0; c <= v.exp_end + 1; c++) begin
      if (c > 0) @(negedge clk_i);
      strobe_i = (c == 0) || (c == v.ovr_at);
      pause_i  = (v.pause_at >= 0) && (c >= v.pause_at);
      clear_i  = (c == v.clr_at);
      d = '0;
      for (int k = 0; k < N; k++) begin
        if (v.dly[k] != 0 && c == int'(v.exp_start[k]) + int'(v.dly[k])) d[k] = 1'b1;
      end
      if (c == v.stray_at) d = d | v.stray_mask;
      stage_done_i = d;
      if (c == 1) check($sformatf("v%0d_busy_first", id), busy_o, active);
      if (active && c == v.exp_end - 1) check($sformatf("v%0d_busy_last", id), busy_o, 1);
      if (c == v.exp_end) begin
        if (v.exp_inc) exp_frames = exp_frames + 16'd1;
        check($sformatf("v%0d_busy_end", id), busy_o, 0);
        check($sformatf("v%0d_frame_cnt", id), frame_cnt_o, exp_frames);
        check($sformatf("v%0d_overrun", id), overrun_o, v.exp_ovr);
        check($sformatf("v%0d_timeout", id), timeout_o, v.exp_tmo);
      end
    end
    @(negedge clk_i);
    strobe_i = 0; pause_i = 0; stage_done_i = '0; clear_i = 1;
    @(negedge clk_i);
    clear_i = 0;
    check($sformatf("v%0d_overrun_cleared", id), overrun_o, 0);
    check($sformatf("v%0d_timeout_cleared", id), timeout_o, 0);
    check($sformatf("v%0d_starts_pending", id), sb.size(), 0);
    sb.delete();
  endtask

  vec_t vecs[8];

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    vecs[0] = mk(-1, 3,3,3,3, -1,-1,-1,4'b0000, 1,5,9,13,  17, 0,0,1); // normal frame
    vecs[1] = mk(-1, 3,3,3,3, 11,11,-1,4'b0000, 1,5,9,13,  17, 1,0,1); // overrun in stage 2 wait, clear coincident
    vecs[2] = mk(-1, 3,0,3,3, -1,-1,-1,4'b0000, 1,5,14,18, 22, 0,1,1); // stage 1 times out
    vecs[3] = mk( 0, 0,0,0,0, -1,-1, 2,4'b0001, 0,0,0,0,   4,  0,0,0); // paused strobe
    vecs[4] = mk(-1, 4,3,3,3, -1,-1, 3,4'b1000, 1,6,10,14, 18, 0,0,1); // stray done[3] in stage 0 wait
    vecs[5] = mk(-1, 3,3,3,3, 16,-1,-1,4'b0000, 1,5,9,13,  17, 1,0,1); // strobe on final done
    vecs[6] = mk(-1, 2,2,2,2, -1,-1,-1,4'b0000, 1,4,7,10,  13, 0,0,1); // fastest done
    vecs[7] = mk( 3, 3,3,3,3, -1,-1,-1,4'b0000, 1,5,9,13,  17, 0,0,1); // pause raised mid-frame

    rst_i = 1; strobe_i = 0; pause_i = 0; clear_i = 0; stage_done_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_busy", busy_o, 0);
    check("rst_start", stage_start_o, 0);
    check("rst_overrun", overrun_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_frame_cnt", frame_cnt_o, 0);
    rst_i = 0;
    mon_en = 1;
    @(negedge clk_i);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Counter wrap: preload 65535, then one more frame.
    @(negedge clk_i);
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk_i);
    release dut.frame_cnt_q;
    @(negedge clk_i);
    check("wrap_preload", frame_cnt_o, 16'hFFFF);
    exp_frames = 16'hFFFF;
    run_vec(8, vecs[0]);
    check("wrap_zero", frame_cnt_o, 0);

    // Reset during stage 1 wait, with overrun already set.
    @(negedge clk_i);
    s = cyc;
    begin
      ev_t e;
      e.cyc = s + 1; e.val = 4'b0001; sb.push_back(e);
      e.cyc = s + 5; e.val = 4'b0010; sb.push_back(e);
    end
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) @(negedge clk_i);
      strobe_i     = (c == 0) || (c == 6);
      stage_done_i = (c == 4) ? 4'b0001 : 4'b0000;
      rst_i        = (c == 7);
      if (c == 7) check("pre_rst_overrun", overrun_o, 1);
      if (c == 8) begin
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_start", stage_start_o, 0);
        check("mid_rst_overrun", overrun_o, 0);
        check("mid_rst_timeout", timeout_o, 0);
        check("mid_rst_frame_cnt", frame_cnt_o, 0);
      end
      if (c == 14) check("post_rst_busy", busy_o, 0);
    end
    check("rst_starts_pending", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
